// File: rtl/acc_sched.sv
// Round-robin scheduler that shares one serial 128-bit accumulator between N_REQ requesters.
// Words are shifted out MSB-first on acc_rx/acc_add, followed by a one-cycle commit gap; clears are arbitrated alongside.
module acc_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     clr_req,
  output logic                     clr_ack,
  output logic                     acc_rx,
  output logic                     acc_add,
  output logic                     acc_clear,
  output logic                     busy,
  output logic                     sum_valid,
  output logic [$clog2(N_REQ)-1:0] sum_src,
  output logic [15:0]              word_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, CLEAR} state_t;

  state_t             state, state_next;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gnt;
  logic               gnt_found;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   words [N_REQ];
  logic [2*N_REQ-1:0] rot;

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Rotate the valid vector so bit 0 is the requester right after the last winner.
  always_comb begin
    int sum;
    rot       = {req_valid, req_valid} >> (int'(ptr) + 1);
    gnt       = '0;
    gnt_found = 1'b0;
    sum       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && rot[k]) begin
        gnt_found = 1'b1;
        sum       = int'(ptr) + 1 + k;
        if (sum >= N_REQ) sum = sum - N_REQ;
        gnt       = IW'(sum);
      end
    end
  end

  assign req_ready = (nRst && state == IDLE && !clr_req && gnt_found) ? (N_REQ'(1) << gnt) : '0;
  assign clr_ack   = nRst && state == IDLE && clr_req;
  assign busy      = state != IDLE;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clr_req)        state_next = CLEAR;
        else if (gnt_found) state_next = SHIFT;
      end
      SHIFT:   if (cnt == '0) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The captured word is pre-shifted by one because its MSB leaves on the accept edge.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ptr       <= IW'(N_REQ - 1);
      cnt       <= '0;
      shreg     <= '0;
      acc_rx    <= 1'b0;
      acc_add   <= 1'b0;
      acc_clear <= 1'b0;
      sum_valid <= 1'b0;
      sum_src   <= '0;
      word_cnt  <= '0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            acc_clear <= 1'b1;
          end else if (gnt_found) begin
            shreg   <= words[gnt] << 1;
            acc_rx  <= words[gnt][WIDTH-1];
            acc_add <= 1'b1;
            cnt     <= CW'(WIDTH - 1);
            ptr     <= gnt;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            acc_rx <= shreg[WIDTH-1];
            shreg  <= shreg << 1;
            cnt    <= cnt - CW'(1);
          end else begin
            acc_rx  <= 1'b0;
            acc_add <= 1'b0;
          end
        end
        COMMIT: begin
          sum_valid <= 1'b1;
          sum_src   <= ptr;
          word_cnt  <= word_cnt + 16'd1;
        end
        CLEAR: begin
          acc_clear <= 1'b0;
          word_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sched.sv
// Randomized bench for acc_sched: a behavioural accumulator plus a timeline scoreboard
// that schedules the expected per-cycle outputs whenever a word or clear is accepted.
module tb_acc_sched;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int IW    = 2;
  localparam int RING  = 64;

  logic                   clk = 1'b0;
  logic                   nRst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   clr_req;
  logic                   clr_ack;
  logic                   acc_rx, acc_add, acc_clear, busy, sum_valid;
  logic [IW-1:0]          sum_src;
  logic [15:0]            word_cnt;

  always #5 clk = ~clk;

  acc_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .nRst(nRst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .clr_req(clr_req), .clr_ack(clr_ack),
    .acc_rx(acc_rx), .acc_add(acc_add), .acc_clear(acc_clear), .busy(busy),
    .sum_valid(sum_valid), .sum_src(sum_src), .word_cnt(word_cnt)
  );

  // Stand-in for the accumulator: shift while add is high, add on the falling add edge.
  logic [127:0] acc_shift, acc_big;
  logic         acc_add_d;
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      acc_shift <= '0;
      acc_big   <= '0;
      acc_add_d <= 1'b0;
    end else begin
      acc_add_d <= acc_add;
      if (acc_clear && !acc_add) acc_big <= '0;
      else if (acc_add) acc_shift <= {acc_shift[126:0], acc_rx};
      else if (acc_add_d) begin
        acc_big   <= acc_big + acc_shift;
        acc_shift <= '0;
      end
    end
  end

  int n_compared = 0;
  int n_mismatch = 0;

  int           cyc, next_idle, m_ptr;
  logic [15:0]  m_wcnt;
  logic [127:0] m_big;
  logic [IW-1:0] m_src;
  bit           r_add [RING], r_rx [RING], r_clr [RING], r_sv [RING], r_commit [RING], r_zero [RING];
  int           r_src [RING];
  logic [127:0] r_word [RING];

  logic [N_REQ-1:0] pend, sticky, xfer;
  logic             pend_clr, clr_xfer;
  bit               rand_on, rand_data;
  logic [WIDTH-1:0] word_val [N_REQ];

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus();
    logic [N_REQ-1:0] v;
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = sticky[i] | pend[i] | (rand_on && $urandom_range(0, 4) == 0);
      if (rand_data) word_val[i] = $urandom;
      req_data[i*WIDTH +: WIDTH] = word_val[i];
    end
    req_valid = v;
    clr_req   = pend_clr | (rand_on && $urandom_range(0, 59) == 0);
  endtask

  task automatic modelReset();
    for (int s = 0; s < RING; s++) begin
      r_add[s] = 0; r_rx[s] = 0; r_clr[s] = 0; r_sv[s] = 0; r_commit[s] = 0; r_zero[s] = 0;
      r_src[s] = 0; r_word[s] = '0;
    end
    next_idle = cyc;
    m_ptr     = N_REQ - 1;
    m_wcnt    = '0;
    m_big     = '0;
    m_src     = '0;
  endtask

  // Called at a falling edge: drive, check this cycle, then book the consequences of any transfer.
  task automatic stepCycle();
    int s, g, j;
    bit idle;
    logic [N_REQ-1:0] exp_ready;
    applyStimulus();
    #1;
    s = cyc % RING;
    if (r_commit[s]) begin
      m_src  = IW'(r_src[s]);
      m_wcnt = m_wcnt + 16'd1;
      m_big  = m_big + r_word[s];
    end
    if (r_zero[s]) begin
      m_wcnt = '0;
      m_big  = '0;
    end
    checkOutput("acc_add", acc_add, r_add[s]);
    checkOutput("acc_rx", acc_rx, r_rx[s]);
    checkOutput("acc_clear", acc_clear, r_clr[s]);
    checkOutput("sum_valid", sum_valid, r_sv[s]);
    checkOutput("sum_src", sum_src, m_src);
    checkOutput("word_cnt", word_cnt, m_wcnt);
    checkOutput("busy", busy, cyc < next_idle);
    checkOutput("big", acc_big, m_big);

    idle = cyc >= next_idle;
    exp_ready = '0;
    g = -1;
    if (idle && !clr_req)
      for (int k = 1; k <= N_REQ; k++) begin
        j = (m_ptr + k) % N_REQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("clr_ack", clr_ack, idle && clr_req);

    r_add[s] = 0; r_rx[s] = 0; r_clr[s] = 0; r_sv[s] = 0; r_commit[s] = 0; r_zero[s] = 0;
    xfer     = exp_ready & req_valid;
    clr_xfer = idle && clr_req;
    if (clr_xfer) begin
      r_clr[(cyc + 1) % RING]  = 1;
      r_zero[(cyc + 2) % RING] = 1;
      next_idle = cyc + 2;
    end
    if (g >= 0) begin
      for (int k = 1; k <= WIDTH; k++) begin
        r_add[(cyc + k) % RING] = 1;
        r_rx[(cyc + k) % RING]  = word_val[g][WIDTH-k];
      end
      r_sv[(cyc + WIDTH + 2) % RING]     = 1;
      r_commit[(cyc + WIDTH + 2) % RING] = 1;
      r_src[(cyc + WIDTH + 2) % RING]    = g;
      r_word[(cyc + WIDTH + 2) % RING]   = 128'(word_val[g]);
      next_idle = cyc + WIDTH + 2;
      m_ptr = g;
    end
    cyc++;
    pend     = req_valid & ~xfer;
    pend_clr = clr_req & ~clr_xfer;
    @(negedge clk);
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic doClear();
    pend_clr = 1'b1;
    runCycles(3);
  endtask

  initial begin
    int guard;
    nRst = 1'b0; req_valid = '0; req_data = '0; clr_req = 1'b0;
    pend = '0; sticky = '0; pend_clr = 1'b0; rand_on = 0; rand_data = 0;
    for (int i = 0; i < N_REQ; i++) word_val[i] = '0;
    cyc = 0;
    modelReset();
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    runCycles(2);

    word_val[0] = 32'h0000_0005; pend = 4'b0001;
    runCycles(40);
    checkOutput("one_word_big", acc_big, 128'd5);
    checkOutput("one_word_cnt", word_cnt, 16'd1);

    doClear();
    word_val[0] = 1; word_val[1] = 2; word_val[2] = 3; word_val[3] = 4; pend = 4'b1111;
    runCycles(4 * (WIDTH + 2) + 4);
    checkOutput("four_big", acc_big, 128'd10);
    checkOutput("four_cnt", word_cnt, 16'd4);

    doClear();
    word_val[1] = 32'hFFFF_FFFF; word_val[2] = 32'hFFFF_FFFF; pend = 4'b0110;
    runCycles(2 * (WIDTH + 2) + 4);
    checkOutput("ones_big", acc_big, 128'h1_FFFF_FFFE);

    doClear();
    word_val[0] = 7; pend = 4'b0001;
    runCycles(WIDTH + 4);
    checkOutput("seven_big", acc_big, 128'd7);
    word_val[2] = 9; pend = 4'b0100; pend_clr = 1'b1;
    runCycles(WIDTH + 8);
    checkOutput("clr_first_big", acc_big, 128'd9);
    checkOutput("clr_first_cnt", word_cnt, 16'd1);

    word_val[0] = 1; word_val[3] = 2; sticky = 4'b1001;
    runCycles(4 * (WIDTH + 2) + 4);
    sticky = '0;
    runCycles(80);

    rand_on = 1; rand_data = 1;
    runCycles(3000);

    rand_on = 0; rand_data = 0;
    guard = 0;
    while ((pend != '0 || pend_clr || cyc < next_idle) && guard < 500) begin
      stepCycle();
      guard++;
    end
    checkOutput("drain_timeout", guard >= 500, 1'b0);
    word_val[1] = 32'hA5A5_0F0F; word_val[2] = 32'h0000_0123; pend = 4'b0010;
    runCycles(10);
    nRst = 1'b0;
    pend = 4'b0100;
    applyStimulus();
    #1;
    checkOutput("rst_acc_rx", acc_rx, 1'b0);
    checkOutput("rst_acc_add", acc_add, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_word_cnt", word_cnt, 16'd0);
    checkOutput("rst_big", acc_big, 128'd0);
    checkOutput("rst_ready", req_ready, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
    modelReset();
    runCycles(WIDTH + 6);
    checkOutput("post_rst_big", acc_big, 128'h123);

    rand_on = 1; rand_data = 1;
    runCycles(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
